// File: rtl/prog_chain_loader_if.sv
// prog_chain_loader_if: config stream, scan-chain head/tail and status signals of the chain loader.
interface prog_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic              cfg_start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              prog_we;
    logic              prog_din;
    logic              prog_dout;
    logic              prog_we_o;
    logic              prog_done;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
    logic              busy;
    logic              chain_err;

    modport master (
        input  cfg_start, cfg_data, cfg_valid, prog_dout, prog_we_o,
        output cfg_ready, prog_we, prog_din, prog_done, rb_data, rb_valid, busy, chain_err
    );

    modport slave (
        output cfg_start, cfg_data, cfg_valid, prog_dout, prog_we_o,
        input  cfg_ready, prog_we, prog_din, prog_done, rb_data, rb_valid, busy, chain_err
    );
endinterface

// File: rtl/prog_chain_loader.sv
// prog_chain_loader: shifts configuration words LSB first into a scan chain head and
// assembles the bits falling out of the chain tail into readback words.
module prog_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input logic                 prog_clk,
    input logic                 prog_rst,
    prog_chain_loader_if.master bus
);
    localparam int WB_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d, hold_q, hold_d;
    logic [WORD_W-1:0] rb_acc_q, rb_acc_d, rb_data_q, rb_data_d;
    logic              hold_vld_q, hold_vld_d;
    logic [WB_W-1:0]   wbits_q, wbits_d, rb_idx_q, rb_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, acc_q, acc_d;
    logic              seen_q, seen_d, we_q, we_d, din_q, din_d;
    logic              ready_q, ready_d, rbv_q, rbv_d, done_q, done_d;
    logic              busy_q, busy_d, err_q, err_d;

    logic [CNT_W-1:0]  cnt_inc, rem_acc, take;
    logic [WORD_W-1:0] rb_word;
    logic              hs, start, last_bit, word_end, rb_full;

    // Bits a word may still contribute, given how many chain bits remain.
    function automatic logic [WB_W-1:0] fit(input logic [CNT_W-1:0] rem);
        return (int'(rem) < WORD_W) ? WB_W'(rem) : WB_W'(WORD_W);
    endfunction

    assign hs       = bus.cfg_valid && ready_q;
    assign start    = bus.cfg_start && (state_q == IDLE || state_q == DONE);
    assign cnt_inc  = cnt_q + 1'b1;
    assign last_bit = cnt_inc == LEN;
    assign word_end = wbits_q == WB_W'(1);
    assign rem_acc  = LEN - acc_q;
    assign take     = (int'(rem_acc) < WORD_W) ? rem_acc : CNT_W'(WORD_W);
    assign rb_word  = rb_acc_q | (WORD_W'(bus.prog_dout) << rb_idx_q);
    assign rb_full  = rb_idx_q == WB_W'(WORD_W - 1) || last_bit;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        wbits_d    = wbits_q;
        cnt_d      = cnt_q;
        acc_d      = hs ? acc_q + take : acc_q;
        rb_acc_d   = rb_acc_q;
        rb_idx_d   = rb_idx_q;
        rb_data_d  = rb_data_q;
        rbv_d      = 1'b0;
        seen_d     = seen_q | (busy_q & bus.prog_we_o);
        err_d      = err_q;
        if (start) begin
            state_d    = LOAD;
            cnt_d      = '0;
            acc_d      = '0;
            hold_vld_d = 1'b0;
            rb_acc_d   = '0;
            rb_idx_d   = '0;
            seen_d     = 1'b0;
            err_d      = 1'b0;
        end else if (state_q == LOAD && hs) begin
            state_d = SHIFT;
            shift_d = bus.cfg_data;
            wbits_d = fit(LEN - cnt_q);
        end else if (state_q == SHIFT) begin
            cnt_d     = cnt_inc;
            rb_acc_d  = rb_full ? '0 : rb_word;
            rb_idx_d  = rb_full ? '0 : rb_idx_q + 1'b1;
            rb_data_d = rb_full ? rb_word : rb_data_q;
            rbv_d     = rb_full;
            if (hs) begin
                hold_d     = bus.cfg_data;
                hold_vld_d = 1'b1;
            end
            // A word accepted on the very edge the current one ends bypasses the holding register.
            if (!word_end) begin
                shift_d = shift_q >> 1;
                wbits_d = wbits_q - 1'b1;
            end else if (last_bit) begin
                state_d = DONE;
                err_d   = !(seen_q | bus.prog_we_o);
            end else if (hold_vld_q || hs) begin
                shift_d    = hold_vld_q ? hold_q : bus.cfg_data;
                hold_vld_d = 1'b0;
                wbits_d    = fit(LEN - cnt_inc);
            end else begin
                state_d = LOAD;
            end
        end
        busy_d  = state_d == LOAD || state_d == SHIFT;
        we_d    = state_d == SHIFT;
        din_d   = we_d & shift_d[0];
        done_d  = state_d == DONE;
        ready_d = state_d == LOAD || (state_d == SHIFT && !hold_vld_d && acc_d != LEN);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            wbits_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            rb_acc_q   <= '0;
            rb_idx_q   <= '0;
            rb_data_q  <= '0;
            rbv_q      <= 1'b0;
            seen_q     <= 1'b0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            din_q      <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            wbits_q    <= wbits_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rb_acc_q   <= rb_acc_d;
            rb_idx_q   <= rb_idx_d;
            rb_data_q  <= rb_data_d;
            rbv_q      <= rbv_d;
            seen_q     <= seen_d;
            err_q      <= err_d;
            we_q       <= we_d;
            din_q      <= din_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.cfg_ready = ready_q;
    assign bus.prog_we   = we_q;
    assign bus.prog_din  = din_q;
    assign bus.prog_done = done_q;
    assign bus.rb_data   = rb_data_q;
    assign bus.rb_valid  = rbv_q;
    assign bus.busy      = busy_q;
    assign bus.chain_err = err_q;
endmodule

// File: doc/prog_chain_loader.md
Name: prog_chain_loader

Overview:
- Drives the serial configuration scan chain of a row or array of tiles (the prog_we/prog_din in, prog_dout/prog_we_o out chain), from the controller end.
- Accepts configuration words over a valid/ready stream and shifts them bit-serially into the chain head.
- Captures bits falling out of the chain tail as readback words.
- Asserts prog_done once exactly CHAIN_LEN bits have been shifted.

Parameters:
- CHAIN_LEN, 1024, total configuration bits in the chain; 1 or more.
- WORD_W, 32, width of configuration and readback words.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- prog_clk  input  1  configuration clock; the only clock.
- prog_rst  input  1  synchronous, active-high reset.
- cfg_start  input  1  one-cycle pulse that begins a programming pass; ignored unless in IDLE or DONE.
- cfg_data  input  WORD_W  configuration word, shifted LSB first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- prog_we  output  1  chain shift enable, driven to the chain head.
- prog_din  output  1  serial bit to the chain head.
- prog_dout  input  1  serial bit from the chain tail.
- prog_we_o  input  1  shift enable returned from the chain tail; used for continuity checking.
- prog_done  output  1  configuration complete.
- rb_data  output  WORD_W  readback word; first bit out of the chain is in the LSB.
- rb_valid  output  1  one-cycle strobe for rb_data; there is no backpressure.
- busy  output  1  high in LOAD or SHIFT.
- chain_err  output  1  sticky flag; prog_we_o not seen during the pass.

Behaviour:
- Reset values: all outputs 0; state IDLE; bit counter 0; holding register empty.
- Outputs: prog_we, prog_din, cfg_ready, rb_valid and prog_done are registered.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE/DONE -> LOAD on cfg_start.
  - On entry: clear prog_done, chain_err, bit counter and readback accumulator.
- LOAD:
  - cfg_ready=1.
  - On cfg_valid&&cfg_ready, move cfg_data into the shift register and go to SHIFT.
  - While waiting, prog_we=0.
- SHIFT:
  - Each cycle: prog_we=1, prog_din = shift_reg[0], shift_reg >>= 1, bit counter +1.
  - Word bits are consumed LSB first.
  - Holding register: cfg_ready=1 in SHIFT while the holding register is empty. A word accepted there is transferred to the shift register on the cycle after the current word's last bit, with no gap (back-to-back streaming).
  - Holding register empty when the current word finishes and more bits remain: go to LOAD. prog_we=0 during the gap; the gap has no length limit.
- Final word:
  - When CHAIN_LEN is not a multiple of WORD_W, only the low (CHAIN_LEN mod WORD_W) bits of the last word are shifted; its upper bits are discarded.
  - No word is accepted once CHAIN_LEN bits have been accepted: cfg_ready=0.
- Completion:
  - When the bit counter reaches CHAIN_LEN, the cycle after the last prog_we=1 has prog_we=0, prog_done=1, and the state is DONE.
  - prog_done holds until the next cfg_start or reset.
- Readback:
  - In every cycle with prog_we=1, sample prog_dout at the same edge into the readback accumulator at bit index (bitcount mod WORD_W).
  - rb_valid pulses the cycle after WORD_W bits are collected.
  - If a final partial word exists, it pulses after the last shifted bit, with the unfilled upper bits = 0.
  - Total rb_valid pulses per pass = ceil(CHAIN_LEN/WORD_W).
- Continuity check:
  - Latch a flag when prog_we_o=1 is sampled at any point during the pass.
  - On entering DONE, chain_err = !flag.
- Boundaries:
  - cfg_start while busy: ignored.
  - cfg_valid outside LOAD/SHIFT: ignored, nothing consumed.
  - prog_rst mid-pass: the next cycle has prog_we=0, prog_done=0, state IDLE. Partial readback is discarded, with no rb_valid pulse.
  - CHAIN_LEN=1: one word accepted, one shift cycle, one rb_valid pulse.

Test Plan:
1. CHAIN_LEN=40, WORD_W=16, words 0xA5A5, 0x0FF0, 0x00C3 with cfg_valid always high -> 40 consecutive prog_we=1 cycles. prog_din sequence = 1,0,1,0,0,1,0,1,… The upper 8 bits of 0x00C3 are not shifted. prog_done=1 the cycle after the 40th shift.
2. Chain model is a 40-bit shift register preloaded 0x12_3456_789A -> rb_data strobes 0x789A, 0x3456, 0x0012 (3 pulses).
3. cfg_valid deasserted for 5 cycles between word 1 and word 2 -> prog_we=0 for those gap cycles. Shifted bit total is still 40; prog_done is reached.
4. Chain model holds prog_we_o=0 throughout -> chain_err=1 at DONE. With prog_we_o looped from prog_we delayed 3 cycles -> chain_err=0.
5. prog_rst asserted after 20 shifts -> the next cycle has prog_we=0, busy=0, prog_done=0. A new cfg_start then completes a full 40-bit pass correctly.
6. cfg_start pulsed during SHIFT -> no effect: the count continues and a single prog_done occurs. A second cfg_start in DONE -> prog_done cleared and a new pass begins.
